// File: rtl/subleq_core_p_if.sv
// Memory bus of the SUBLEQ core: one request/ack handshake carrying
// either a read (load) or a write (store).
interface subleq_core_p_if #(
  parameter int WORD_SIZE = 16
);
  logic                 req;
  logic                 ack;
  logic                 load;
  logic                 store;
  logic [WORD_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] data_out;
  logic [WORD_SIZE-1:0] data_in;

  modport master (output req, load, store, addr, data_out, input ack, data_in);
  modport slave  (input req, load, store, addr, data_out, output ack, data_in);
endinterface

// File: rtl/subleq_core_p.sv
// Multi-cycle SUBLEQ core: mem[B] -= mem[A]; branch to C when the result
// is <= 0. One memory access per state, optional single-step pausing, and a
// halt once the PC lands in the upper half of the address space.
module subleq_core_p #(
  parameter int WORD_SIZE = 16,
  parameter int RESET_PC  = 0,
  parameter int CNT_WIDTH = 32,
  parameter bit STEP_MODE = 1'b0
) (
  input  logic                 clk,
  input  logic                 areset,
  subleq_core_p_if.master      bus,
  input  logic                 step,
  output logic                 halted,
  output logic [WORD_SIZE-1:0] pc_out,
  output logic [CNT_WIDTH-1:0] instr_count
);
  localparam logic [WORD_SIZE-1:0] PC0 = WORD_SIZE'(RESET_PC);

  typedef enum logic [3:0] {
    FETCH_A, DEREF_A, FETCH_B, DEREF_B, STORE_SUB, FETCH_C, BRANCH, PAUSE, HALT
  } state_t;

  state_t state, state_n, mem_next;

  logic [WORD_SIZE-1:0] pc, a_ptr, b_ptr, a_val, b_val, c_tgt;
  logic [WORD_SIZE-1:0] diff, pc_next, addr_c;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 leq, leq_now, run;
  logic                 mem_st, req_c, xfer;

  assign diff    = b_val - a_val;
  assign leq_now = diff[WORD_SIZE-1] | (diff == '0);
  assign pc_next = leq ? c_tgt : pc + WORD_SIZE'(3);
  // run holds the bus quiet until the first edge after reset release
  assign req_c   = run & mem_st;
  assign xfer    = req_c & bus.ack;

  assign bus.req      = req_c;
  assign bus.load     = req_c & (state != STORE_SUB);
  assign bus.store    = req_c & (state == STORE_SUB);
  assign bus.addr     = req_c ? addr_c : '0;
  assign bus.data_out = (req_c && state == STORE_SUB) ? diff : '0;

  assign halted      = (state == HALT);
  assign pc_out      = pc;
  assign instr_count = cnt;

  // State register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= FETCH_A;
    else         state <= state_n;
  end

  // Next state, bus address and memory-phase decode
  always_comb begin
    state_n  = state;
    mem_next = state;
    mem_st   = 1'b0;
    addr_c   = '0;
    case (state)
      FETCH_A:   begin mem_st = 1'b1; addr_c = pc;                   mem_next = DEREF_A;   end
      DEREF_A:   begin mem_st = 1'b1; addr_c = a_ptr;                mem_next = FETCH_B;   end
      FETCH_B:   begin mem_st = 1'b1; addr_c = pc + WORD_SIZE'(1);   mem_next = DEREF_B;   end
      DEREF_B:   begin mem_st = 1'b1; addr_c = b_ptr;                mem_next = STORE_SUB; end
      // C is only worth fetching when the branch will be taken
      STORE_SUB: begin mem_st = 1'b1; addr_c = b_ptr; mem_next = leq_now ? FETCH_C : BRANCH; end
      FETCH_C:   begin mem_st = 1'b1; addr_c = pc + WORD_SIZE'(2);   mem_next = BRANCH;    end
      BRANCH:    state_n = pc_next[WORD_SIZE-1] ? HALT : (STEP_MODE ? PAUSE : FETCH_A);
      PAUSE:     if (step) state_n = FETCH_A;
      default:   ;
    endcase
    if (xfer) state_n = mem_next;
  end

  // Operand capture on each completed read, PC/counter update in BRANCH
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      run   <= 1'b0;
      pc    <= PC0;
      cnt   <= '0;
      a_ptr <= '0;
      b_ptr <= '0;
      a_val <= '0;
      b_val <= '0;
      c_tgt <= '0;
      leq   <= 1'b0;
    end else begin
      run <= 1'b1;
      if (xfer) begin
        case (state)
          FETCH_A:   a_ptr <= bus.data_in;
          DEREF_A:   a_val <= bus.data_in;
          FETCH_B:   b_ptr <= bus.data_in;
          DEREF_B:   b_val <= bus.data_in;
          STORE_SUB: leq   <= leq_now;
          FETCH_C:   c_tgt <= bus.data_in;
          default:   ;
        endcase
      end
      if (state == BRANCH) begin
        pc <= pc_next;
        if (cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: doc/subleq_core_p.md
SUBLEQ_CORE_P -- requirements
Module: subleq_core_p

Interface
REQ-001 Parameter WORD_SIZE, default 16: data and address width in bits.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 Parameter CNT_WIDTH, default 32: width of the retired-instruction counter.
REQ-004 Parameter STEP_MODE, default 0: 1 enables single-step pausing after each instruction.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 areset  input  1  asynchronous, active-low reset; 0 resets the block immediately, release is synchronous to clk.
REQ-007 req  output  1  memory transaction request.
REQ-008 ack  input  1  memory completion; sampled on a rising edge while req=1.
REQ-009 load  output  1  current transaction is a read.
REQ-010 store  output  1  current transaction is a write.
REQ-011 addr  output  WORD_SIZE  transaction address.
REQ-012 data_out  output  WORD_SIZE  write data.
REQ-013 data_in  input  WORD_SIZE  read data, valid in the cycle ack=1.
REQ-014 step  input  1  single-cycle pulse releasing PAUSE.
REQ-015 halted  output  1  1 while in HALT.
REQ-016 pc_out  output  WORD_SIZE  current PC.
REQ-017 instr_count  output  CNT_WIDTH  retired-instruction count.

Function
REQ-018 Instruction at PC is the triple A=mem[PC], B=mem[PC+1], C=mem[PC+2]; semantics: mem[B] := mem[B] - mem[A]; result <= 0 (signed two's complement) -> PC := C, else PC := PC+3.
REQ-019 States: FETCH_A, DEREF_A, FETCH_B, DEREF_B, STORE_SUB, FETCH_C, BRANCH, PAUSE, HALT.
REQ-020 Memory states (FETCH_A, DEREF_A, FETCH_B, DEREF_B, STORE_SUB, FETCH_C) drive req=1 and hold addr, load, store, data_out stable until an edge with ack=1, then advance; ack in the same cycle as req is legal (zero wait).
REQ-021 load=1 in all memory states except STORE_SUB; store=1 only in STORE_SUB; load and store never both 1; both 0 when req=0.
REQ-022 Addresses: FETCH_A PC, DEREF_A A, FETCH_B PC+1, DEREF_B B, STORE_SUB B, FETCH_C PC+2; PC+k wraps modulo 2^WORD_SIZE.
REQ-023 STORE_SUB writes data_out = mem[B] - mem[A] modulo 2^WORD_SIZE; leq flag latched from that result.
REQ-024 After STORE_SUB ack: leq=1 -> FETCH_C; leq=0 -> BRANCH with PC+3 (C is not fetched).
REQ-025 BRANCH: one cycle, req=0, updates PC, increments instr_count (saturating at all-ones).
REQ-026 Halt: if the new PC has MSB=1, BRANCH -> HALT; HALT is absorbing until reset, req=0, halted=1; the halting instruction is counted.
REQ-027 STEP_MODE=1 and not halting: BRANCH -> PAUSE; PAUSE holds req=0 until step=1 sampled, then -> FETCH_A; step ignored in all other states.
REQ-028 STEP_MODE=0: BRANCH -> FETCH_A.
REQ-029 Zero-wait instruction latency: 7 cycles when branching, 6 when not.
REQ-030 ack while req=0 ignored.

Reset
REQ-031 areset=0 asynchronously forces: state FETCH_A, PC=RESET_PC, instr_count=0, req=0, load=0, store=0, addr=0, data_out=0, halted=0, internal A/B/operand registers 0.
REQ-032 Reset mid-transaction (including STORE_SUB) drops req in the same instant; an ack arriving after reset assertion is ignored.
REQ-033 After areset returns to 1, first rising edge begins FETCH_A at RESET_PC with req=1.

Verification
REQ-034 W=16, zero wait: mem[0..2]=0x0010,0x0011,0xFFFF, mem[0x10]=5, mem[0x11]=5 -> mem[0x11]=0, 6 transactions, halted=1 7 cycles after reset release, instr_count=1.
REQ-035 mem[0..2]=0x0010,0x0011,0x0009, mem[0x10]=2, mem[0x11]=5 -> mem[0x11]=3, no access to addr 2, pc_out=3, instr_count=1.
REQ-036 Wrap: mem[0x10]=0x0001, mem[0x11]=0x8000 -> stored 0x7FFF, leq=0, PC+3.
REQ-037 Ack delayed 3 cycles per transaction -> req, addr, load/store, data_out constant throughout each wait; result identical to REQ-034.
REQ-038 STEP_MODE=1: after first instruction core sits in PAUSE with req=0 for 20 cycles; one step pulse -> exactly one more instruction, instr_count 1 -> 2.
REQ-039 areset=0 while in STORE_SUB before ack -> req=0 immediately, mem[B] unchanged, pc_out=RESET_PC, instr_count=0.
